nat_conn_table: RTL and testbench
=================================

NAT_CONN_TABLE -- requirements
Module: nat_conn_table

Interface
REQ-001 SHALL have parameter HASH_LEN, default 6, giving table depth DEPTH = 2^HASH_LEN per table (legal range 2..8).
REQ-002 SHALL have parameter KEY_W, default 104, giving the key width taken from tuple bits [KEY_W-1:0].
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 tuple_data_0  input  128  outbound tuple {pad, inner_ip[103:72], outer_ip[71:40], inner_port[39:24], outer_port[23:8], proto[7:0]}.
REQ-006 tuple_valid_0 / tuple_ready_0  input / output  1 / 1  channel-0 request handshake.
REQ-007 conn_data_0  output  16  connection index, zero-extended from HASH_LEN bits.
REQ-008 conn_valid_0 / conn_new_0 / conn_err_0  output  1 each  response pulse; new-entry flag; table-full error.
REQ-009 tuple_data_1  input  128  inbound tuple, same bit layout, with [39:24] carrying the translated index.
REQ-010 tuple_valid_1 / tuple_ready_1  input / output  1 / 1  channel-1 request handshake.
REQ-011 conn_data_1  output  16  original inner_port.
REQ-012 conn_valid_1 / conn_miss_1  output  1 each  response pulse; lookup-miss flag.
REQ-013 occupancy  output  HASH_LEN+1  number of live connections.

Function
REQ-014 SHALL hold two tables, RX and TX, each DEPTH entries of {valid bit, KEY_W key, 16-bit value}; an empty slot is valid=0, not key=0.
REQ-015 SHALL compute the hash h(key) as the XOR of key bits [H-1:0], [8+H-1:8], [24+H-1:24], [40+H-1:40] and [72+H-1:72], with H = HASH_LEN.
REQ-016 SHALL implement FSM IDLE -> RX_PROBE -> (TX_INSERT) -> IDLE and IDLE -> TX_PROBE -> IDLE.
REQ-017 SHALL drive tuple_ready_x high only in IDLE and only for the granted channel; a transfer occurs on valid&ready.
REQ-018 SHALL arbitrate round-robin when both channels are valid in IDLE, with channel 0 winning the first contention after reset and the grant alternating thereafter.
REQ-019 RX_PROBE SHALL start at h(key) and compare one slot per cycle, with the address wrapping modulo DEPTH.
REQ-020 RX_PROBE on a match SHALL respond with conn_data_0 = stored index and conn_new_0 = 0, then go to IDLE.
REQ-021 RX_PROBE on an empty slot with occupancy < DEPTH SHALL write key and next_idx into that slot and respond with conn_data_0 = next_idx and conn_new_0 = 1.
REQ-022 After an RX insert, the FSM SHALL go to TX_INSERT.
REQ-023 RX_PROBE after DEPTH probes without a match, or on an empty slot while occupancy == DEPTH, SHALL pulse conn_err_0 and conn_valid_0 with conn_data_0 = 0, perform no write, and go to IDLE.
REQ-024 TX_INSERT SHALL probe from h({inner_ip, outer_ip, next_idx zero-extended to 16, outer_port, proto}) to the first empty slot.
REQ-025 TX_INSERT SHALL store that key with value = inner_port, then increment next_idx (wrapping at DEPTH) and occupancy, and go to IDLE.
REQ-026 TX_PROBE SHALL start at h(tuple_data_1 key); on a match it SHALL respond with conn_data_1 = stored value and conn_miss_1 = 0.
REQ-027 TX_PROBE on an empty slot or after DEPTH probes SHALL respond with conn_miss_1 = 1 and conn_data_1 = 0.
REQ-028 Latency: for a transfer at edge E, the response SHALL be registered at edge E+1+k, where k = number of additional probes beyond the first (minimum 2 cycles valid-to-response).
REQ-029 conn_valid_x SHALL be a single-cycle pulse, and the flag and data outputs SHALL be valid only while it is high.
REQ-030 An outbound lookup issued while TX_INSERT is pending SHALL not be accepted until TX_INSERT completes, so RX and TX are always consistent in IDLE.

Reset
REQ-031 On rst_n low, the block SHALL asynchronously clear all valid bits, set FSM = IDLE, next_idx = 0, occupancy = 0 and round-robin pointer = channel 0, and drive all conn_* outputs to 0 and tuple_ready_0/1 to 0.
REQ-032 Reset asserted mid-probe or mid-insert SHALL abandon the operation with no response, leaving both tables empty.
REQ-033 After rst_n deassertion, tuple_ready SHALL rise on the first clock edge.

Verification (HASH_LEN=4)
REQ-034 Fresh outbound tuple 0x0A000001/0x08080808/1234/80/6 on ch0 -> conn_valid_0 pulse after 2 cycles with conn_new_0=1, conn_data_0=0; occupancy=1.
REQ-035 Repeat the same tuple on ch0 -> conn_new_0=0, conn_data_0=0; occupancy unchanged.
REQ-036 ch1 tuple with inner_port field = 0 and other fields matching the REQ-034 tuple -> conn_data_1=1234, conn_miss_1=0; an unknown tuple -> conn_miss_1=1.
REQ-037 Two tuples with equal h on ch0 -> second response has conn_data_0=1 with probe latency 3 cycles; both are found on ch1.
REQ-038 Insert 16 distinct tuples then a 17th -> conn_err_0=1 and occupancy=16; both channels held valid for 4 requests -> grants alternate 0,1,0,1.
REQ-039 Assert rst_n low during RX_PROBE -> no conn_valid pulse; a subsequent lookup of an earlier tuple -> conn_new_0=1, conn_data_0=0.

Source files
------------

// File: rtl/nat_conn_table.sv
`timescale 1ns/1ps
// NAT connection table: outbound tuples are assigned a connection index (RX table),
// inbound tuples carrying that index are mapped back to the original inner port (TX table).
module nat_conn_table #(
  parameter int HASH_LEN = 6,
  parameter int KEY_W    = 104
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [127:0]      tuple_data_0,
  input  logic              tuple_valid_0,
  output logic              tuple_ready_0,
  output logic [15:0]       conn_data_0,
  output logic              conn_valid_0,
  output logic              conn_new_0,
  output logic              conn_err_0,
  input  logic [127:0]      tuple_data_1,
  input  logic              tuple_valid_1,
  output logic              tuple_ready_1,
  output logic [15:0]       conn_data_1,
  output logic              conn_valid_1,
  output logic              conn_miss_1,
  output logic [HASH_LEN:0] occupancy
);
  localparam int DEPTH = 1 << HASH_LEN;
  localparam logic [KEY_W-1:0] IDX_MASK = KEY_W'(40'hFF_FF00_0000);

  typedef enum logic [1:0] {IDLE, RX_PROBE, TX_INSERT, TX_PROBE} state_t;

  state_t state, state_next;

  logic [DEPTH-1:0] rx_valid, tx_valid;
  logic [KEY_W-1:0] rx_key [DEPTH];
  logic [15:0]      rx_val [DEPTH];
  logic [KEY_W-1:0] tx_key [DEPTH];
  logic [15:0]      tx_val [DEPTH];

  logic [KEY_W-1:0]    key_reg;
  logic [15:0]         port_reg;
  logic [HASH_LEN-1:0] addr_reg, cnt_reg, next_idx;
  logic [HASH_LEN:0]   occ_reg;
  logic                rr_ptr, active;

  logic grant_1, idle_ready, take_0, take_1, contention;
  logic rx_slot_valid, rx_hit, tx_slot_valid, tx_hit, last_probe, full;
  logic rx_we, tx_we;
  logic [KEY_W-1:0] tx_ins_key;
  logic unused_bits;

  function automatic logic [HASH_LEN-1:0] hash(input logic [KEY_W-1:0] k);
    return k[0 +: HASH_LEN] ^ k[8 +: HASH_LEN] ^ k[24 +: HASH_LEN] ^
           k[40 +: HASH_LEN] ^ k[72 +: HASH_LEN];
  endfunction

  // Round robin only matters under contention; a lone requester always gets the grant.
  assign contention    = tuple_valid_0 & tuple_valid_1;
  assign grant_1       = tuple_valid_1 & (~tuple_valid_0 | rr_ptr);
  assign idle_ready    = active & (state == IDLE);
  assign tuple_ready_0 = idle_ready & ~grant_1;
  assign tuple_ready_1 = idle_ready & grant_1;
  assign take_0        = tuple_valid_0 & tuple_ready_0;
  assign take_1        = tuple_valid_1 & tuple_ready_1;

  assign rx_slot_valid = rx_valid[addr_reg];
  assign rx_hit        = rx_slot_valid && (rx_key[addr_reg] == key_reg);
  assign tx_slot_valid = tx_valid[addr_reg];
  assign tx_hit        = tx_slot_valid && (tx_key[addr_reg] == key_reg);
  assign last_probe    = (cnt_reg == HASH_LEN'(DEPTH - 1));
  assign full          = (occ_reg == (HASH_LEN+1)'(DEPTH));
  assign tx_ins_key    = (key_reg & ~IDX_MASK) | (KEY_W'(next_idx) << 24);
  assign occupancy     = occ_reg;
  assign unused_bits   = ^{tuple_data_0[127:KEY_W], tuple_data_1[127:KEY_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    rx_we      = 1'b0;
    tx_we      = 1'b0;
    case (state)
      IDLE: begin
        if (take_0)      state_next = RX_PROBE;
        else if (take_1) state_next = TX_PROBE;
      end
      RX_PROBE: begin
        if (rx_hit) begin
          state_next = IDLE;
        end else if (!rx_slot_valid) begin
          if (full) begin
            state_next = IDLE;
          end else begin
            rx_we      = 1'b1;
            state_next = TX_INSERT;
          end
        end else if (last_probe) begin
          state_next = IDLE;
        end
      end
      TX_INSERT: begin
        if (!tx_slot_valid) begin
          tx_we      = 1'b1;
          state_next = IDLE;
        end
      end
      TX_PROBE: begin
        if (tx_hit || !tx_slot_valid || last_probe) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid     <= '0;
      tx_valid     <= '0;
      key_reg      <= '0;
      port_reg     <= '0;
      addr_reg     <= '0;
      cnt_reg      <= '0;
      next_idx     <= '0;
      occ_reg      <= '0;
      rr_ptr       <= 1'b0;
      active       <= 1'b0;
      conn_valid_0 <= 1'b0;
      conn_new_0   <= 1'b0;
      conn_err_0   <= 1'b0;
      conn_data_0  <= '0;
      conn_valid_1 <= 1'b0;
      conn_miss_1  <= 1'b0;
      conn_data_1  <= '0;
    end else begin
      active       <= 1'b1;
      conn_valid_0 <= 1'b0;
      conn_new_0   <= 1'b0;
      conn_err_0   <= 1'b0;
      conn_data_0  <= '0;
      conn_valid_1 <= 1'b0;
      conn_miss_1  <= 1'b0;
      conn_data_1  <= '0;
      case (state)
        IDLE: begin
          cnt_reg <= '0;
          if (take_0) begin
            key_reg  <= tuple_data_0[KEY_W-1:0];
            port_reg <= tuple_data_0[39:24];
            addr_reg <= hash(tuple_data_0[KEY_W-1:0]);
          end else if (take_1) begin
            key_reg  <= tuple_data_1[KEY_W-1:0];
            addr_reg <= hash(tuple_data_1[KEY_W-1:0]);
          end
          if (contention && (take_0 || take_1)) rr_ptr <= take_0;
        end
        RX_PROBE: begin
          if (rx_hit) begin
            conn_valid_0 <= 1'b1;
            conn_data_0  <= rx_val[addr_reg];
          end else if (rx_we) begin
            // Reuse key/addr registers for the reverse-mapping insert that follows.
            rx_valid[addr_reg] <= 1'b1;
            conn_valid_0       <= 1'b1;
            conn_new_0         <= 1'b1;
            conn_data_0        <= 16'(next_idx);
            key_reg            <= tx_ins_key;
            addr_reg           <= hash(tx_ins_key);
          end else if (!rx_slot_valid || last_probe) begin
            conn_valid_0 <= 1'b1;
            conn_err_0   <= 1'b1;
          end else begin
            addr_reg <= addr_reg + HASH_LEN'(1);
            cnt_reg  <= cnt_reg + HASH_LEN'(1);
          end
        end
        TX_INSERT: begin
          if (tx_we) begin
            tx_valid[addr_reg] <= 1'b1;
            next_idx           <= next_idx + HASH_LEN'(1);
            occ_reg            <= occ_reg + (HASH_LEN+1)'(1);
          end else begin
            addr_reg <= addr_reg + HASH_LEN'(1);
          end
        end
        TX_PROBE: begin
          if (tx_hit) begin
            conn_valid_1 <= 1'b1;
            conn_data_1  <= tx_val[addr_reg];
          end else if (!tx_slot_valid || last_probe) begin
            conn_valid_1 <= 1'b1;
            conn_miss_1  <= 1'b1;
          end else begin
            addr_reg <= addr_reg + HASH_LEN'(1);
            cnt_reg  <= cnt_reg + HASH_LEN'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_we) begin
      rx_key[addr_reg] <= key_reg;
      rx_val[addr_reg] <= 16'(next_idx);
    end
    if (tx_we) begin
      tx_key[addr_reg] <= key_reg;
      tx_val[addr_reg] <= port_reg;
    end
  end

endmodule

// File: tb/tb_nat_conn_table.sv
`timescale 1ns/1ps
// Randomised bench for nat_conn_table (HASH_LEN=4) against a slot-array model
// of the two linear-probing tables, plus directed reset/collision/arbitration cases.
module tb_nat_conn_table;
  localparam int HL = 4;
  localparam int D  = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] tuple_data_0, tuple_data_1;
  logic         tuple_valid_0, tuple_valid_1, tuple_ready_0, tuple_ready_1;
  logic [15:0]  conn_data_0, conn_data_1;
  logic         conn_valid_0, conn_new_0, conn_err_0, conn_valid_1, conn_miss_1;
  logic [HL:0]  occupancy;

  always #5 clk = ~clk;

  nat_conn_table #(.HASH_LEN(HL), .KEY_W(104)) dut (
    .clk(clk), .rst_n(rst_n),
    .tuple_data_0(tuple_data_0), .tuple_valid_0(tuple_valid_0), .tuple_ready_0(tuple_ready_0),
    .conn_data_0(conn_data_0), .conn_valid_0(conn_valid_0), .conn_new_0(conn_new_0), .conn_err_0(conn_err_0),
    .tuple_data_1(tuple_data_1), .tuple_valid_1(tuple_valid_1), .tuple_ready_1(tuple_ready_1),
    .conn_data_1(conn_data_1), .conn_valid_1(conn_valid_1), .conn_miss_1(conn_miss_1),
    .occupancy(occupancy)
  );

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: slot arrays filled by the hashing/probing rules.
  logic [103:0] m_rx_k [D];
  logic [15:0]  m_rx_d [D];
  bit           m_rx_v [D];
  logic [103:0] m_tx_k [D];
  logic [15:0]  m_tx_d [D];
  bit           m_tx_v [D];
  int           m_occ, m_nidx;

  typedef struct { logic [127:0] t; logic [15:0] idx; } conn_t;
  conn_t known[$];

  function automatic logic [3:0] th(input logic [103:0] k);
    return k[3:0] ^ k[11:8] ^ k[27:24] ^ k[43:40] ^ k[75:72];
  endfunction

  function automatic logic [127:0] mk(input logic [31:0] iip, input logic [31:0] oip,
                                      input logic [15:0] ip, input logic [15:0] op, input logic [7:0] pr);
    return {24'h0, iip, oip, ip, op, pr};
  endfunction

  function automatic logic [127:0] rand_tuple();
    return {24'h0, $urandom, $urandom, 16'($urandom), 16'($urandom), 8'($urandom)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_rx_v[i] = 1'b0;
      m_tx_v[i] = 1'b0;
    end
    m_occ  = 0;
    m_nidx = 0;
    known.delete();
  endtask

  // kind: 0 found, 1 new entry, 2 table error
  task automatic model_out(input logic [127:0] t, output int kind, output logic [15:0] data, output int probes);
    logic [103:0] key, tk;
    int s, s2;
    key = t[103:0];
    kind = 2; data = 16'h0; probes = D;
    for (int i = 0; i < D; i++) begin
      s = (int'(th(key)) + i) % D;
      if (m_rx_v[s] && m_rx_k[s] == key) begin
        kind = 0; data = m_rx_d[s]; probes = i + 1;
        break;
      end
      if (!m_rx_v[s]) begin
        probes = i + 1;
        if (m_occ < D) begin
          kind = 1; data = 16'(m_nidx);
          m_rx_v[s] = 1'b1; m_rx_k[s] = key; m_rx_d[s] = 16'(m_nidx);
          tk = key;
          tk[39:24] = 16'(m_nidx);
          for (int j = 0; j < D; j++) begin
            s2 = (int'(th(tk)) + j) % D;
            if (!m_tx_v[s2]) begin
              m_tx_v[s2] = 1'b1; m_tx_k[s2] = tk; m_tx_d[s2] = t[39:24];
              break;
            end
          end
          known.push_back('{t, 16'(m_nidx)});
          m_nidx = (m_nidx + 1) % D;
          m_occ++;
        end
        break;
      end
    end
  endtask

  // kind: 0 hit, 1 miss
  task automatic model_in(input logic [127:0] t, output int kind, output logic [15:0] data, output int probes);
    logic [103:0] key;
    int s;
    key = t[103:0];
    kind = 1; data = 16'h0; probes = D;
    for (int i = 0; i < D; i++) begin
      s = (int'(th(key)) + i) % D;
      if (!m_tx_v[s]) begin
        probes = i + 1;
        break;
      end
      if (m_tx_k[s] == key) begin
        kind = 0; data = m_tx_d[s]; probes = i + 1;
        break;
      end
    end
  endtask

  task automatic run_req(input int ch, input logic [127:0] t, output int lat, output logic [15:0] d,
                         output logic fa, output logic fb);
    int n, kind, probes;
    logic [15:0] md;
    bit seen;
    @(negedge clk);
    if (ch == 0) begin tuple_data_0 = t; tuple_valid_0 = 1'b1; end
    else         begin tuple_data_1 = t; tuple_valid_1 = 1'b1; end
    #1;
    n = 0;
    while (!((ch == 0) ? tuple_ready_0 : tuple_ready_1) && n < 200) begin
      @(negedge clk); #1; n++;
    end
    check_eq("accept_wait", n < 200, 1);
    @(posedge clk); #1;
    tuple_valid_0 = 1'b0;
    tuple_valid_1 = 1'b0;
    check_eq("no_early_resp", (ch == 0) ? conn_valid_0 : conn_valid_1, 0);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk); #1; lat++;
      seen = (ch == 0) ? conn_valid_0 : conn_valid_1;
    end
    check_eq("resp_seen", seen, 1);
    if (ch == 0) begin d = conn_data_0; fa = conn_new_0; fb = conn_err_0; end
    else         begin d = conn_data_1; fa = conn_miss_1; fb = 1'b0; end
    if (ch == 0) begin
      model_out(t, kind, md, probes);
      check_eq("ch0_new", fa, kind == 1);
      check_eq("ch0_err", fb, kind == 2);
    end else begin
      model_in(t, kind, md, probes);
      check_eq("ch1_miss", fa, kind == 1);
    end
    check_eq("resp_data", d, md);
    check_eq("latency", lat, probes);
    @(posedge clk); #1;
    check_eq("single_pulse", (ch == 0) ? conn_valid_0 : conn_valid_1, 0);
    n = 0;
    @(negedge clk); #1;
    while (!tuple_ready_0 && n < 100) begin @(negedge clk); #1; n++; end
    check_eq("idle_wait", n < 100, 1);
    check_eq("occupancy", occupancy, m_occ);
    $display("ch%0d tuple=%h lat=%0d data=%0d flag=%b err=%b occ=%0d", ch, t[103:0], lat, d, fa, fb, occupancy);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ta, tb1, tc, t;
    logic [15:0]  d;
    logic         fa, fb;
    int           lat, n, op, ch, guard;
    bit           g, seen;
    conn_t        k;

    tuple_data_0 = '0; tuple_data_1 = '0;
    tuple_valid_0 = 1'b0; tuple_valid_1 = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready0", tuple_ready_0, 0);
    check_eq("rst_ready1", tuple_ready_1, 0);
    check_eq("rst_valid0", conn_valid_0, 0);
    check_eq("rst_valid1", conn_valid_1, 0);
    check_eq("rst_occ", occupancy, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    check_eq("ready_before_edge", tuple_ready_0, 0);
    @(posedge clk); #1;
    check_eq("ready_first_edge", tuple_ready_0, 1);

    // Fresh tuple, repeat, reverse lookup, unknown reverse lookup.
    ta = mk(32'h0A000001, 32'h08080808, 16'd1234, 16'd80, 8'd6);
    run_req(0, ta, lat, d, fa, fb);
    check_eq("first_new", fa, 1);
    check_eq("first_idx", d, 0);
    check_eq("first_lat", lat, 1);
    check_eq("first_occ", occupancy, 1);
    run_req(0, ta, lat, d, fa, fb);
    check_eq("repeat_new", fa, 0);
    check_eq("repeat_idx", d, 0);
    check_eq("repeat_occ", occupancy, 1);
    tb1 = ta; tb1[39:24] = 16'd0;
    run_req(1, tb1, lat, d, fa, fb);
    check_eq("rev_port", d, 1234);
    check_eq("rev_miss", fa, 0);
    t = mk(32'h0A000001, 32'h08080808, 16'd0, 16'd81, 8'd6);
    run_req(1, t, lat, d, fa, fb);
    check_eq("unknown_miss", fa, 1);
    check_eq("unknown_data", d, 0);

    // Hash collision with the first tuple.
    tc = rand_tuple(); guard = 0;
    while ((th(tc[103:0]) != th(ta[103:0]) || tc == ta) && guard < 1000) begin
      tc = rand_tuple(); guard++;
    end
    run_req(0, tc, lat, d, fa, fb);
    check_eq("coll_idx", d, 1);
    check_eq("coll_lat", lat, 2);
    check_eq("coll_new", fa, 1);
    t = tc; t[39:24] = 16'd1;
    run_req(1, t, lat, d, fa, fb);
    check_eq("coll_rev", d, tc[39:24]);
    run_req(1, tb1, lat, d, fa, fb);
    check_eq("coll_rev_first", d, 1234);

    // Random mix of inserts, repeats, reverse hits and misses.
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 3);
      ch = 0;
      t = rand_tuple();
      if (op == 1 && known.size() > 0) begin
        t = known[$urandom_range(0, known.size() - 1)].t;
      end else if (op == 2 && known.size() > 0) begin
        k = known[$urandom_range(0, known.size() - 1)];
        t = k.t; t[39:24] = k.idx; ch = 1;
      end else if (op == 3) begin
        ch = 1;
      end
      run_req(ch, t, lat, d, fa, fb);
    end

    // Fill the table, then overflow it.
    guard = 0;
    while (m_occ < D && guard < 100) begin
      run_req(0, rand_tuple(), lat, d, fa, fb);
      guard++;
    end
    run_req(0, rand_tuple(), lat, d, fa, fb);
    check_eq("full_err", fb, 1);
    check_eq("full_data", d, 0);
    check_eq("full_occ", occupancy, 16);
    run_req(1, rand_tuple(), lat, d, fa, fb);
    k = known[$urandom_range(0, known.size() - 1)];
    t = k.t; t[39:24] = k.idx;
    run_req(1, t, lat, d, fa, fb);
    check_eq("full_rev_hit", fa, 0);

    // Reset, then both channels held valid: grants must alternate 0,1,0,1.
    @(negedge clk); rst_n = 1'b0; #1;
    check_eq("rst2_occ", occupancy, 0);
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    run_req(0, ta, lat, d, fa, fb);
    @(negedge clk);
    tuple_data_0 = ta; tuple_data_1 = tb1;
    tuple_valid_0 = 1'b1; tuple_valid_1 = 1'b1;
    for (int r = 0; r < 4; r++) begin
      #1;
      n = 0;
      while (!(tuple_ready_0 || tuple_ready_1) && n < 100) begin @(negedge clk); #1; n++; end
      check_eq("arb_wait", n < 100, 1);
      g = tuple_ready_1;
      check_eq("arb_grant", g, r % 2);
      check_eq("arb_excl", tuple_ready_0 && tuple_ready_1, 0);
      @(posedge clk); #1;
      if (r == 3) begin tuple_valid_0 = 1'b0; tuple_valid_1 = 1'b0; end
      lat = 0; seen = 1'b0;
      while (!seen && lat < 100) begin
        @(posedge clk); #1; lat++;
        seen = g ? conn_valid_1 : conn_valid_0;
      end
      check_eq("arb_resp_seen", seen, 1);
      check_eq("arb_data", g ? conn_data_1 : conn_data_0, g ? 1234 : 0);
      $display("arb req=%0d grant=ch%0d data=%0d", r, g, g ? conn_data_1 : conn_data_0);
      @(negedge clk);
    end

    // Reset asserted mid-probe: no response, table empty afterwards.
    @(negedge clk);
    tuple_data_0 = rand_tuple(); tuple_valid_0 = 1'b1; #1;
    n = 0;
    while (!tuple_ready_0 && n < 100) begin @(negedge clk); #1; n++; end
    check_eq("mid_accept", n < 100, 1);
    @(posedge clk); #1;
    tuple_valid_0 = 1'b0;
    rst_n = 1'b0; #1;
    check_eq("mid_rst_occ", occupancy, 0);
    check_eq("mid_rst_ready", tuple_ready_0, 0);
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (conn_valid_0 || conn_valid_1) seen = 1'b1;
    end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    repeat (2) begin
      @(posedge clk); #1;
      if (conn_valid_0 || conn_valid_1) seen = 1'b1;
    end
    check_eq("mid_rst_quiet", seen, 0);
    run_req(0, ta, lat, d, fa, fb);
    check_eq("post_rst_new", fa, 1);
    check_eq("post_rst_idx", d, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
